// File: rtl/pool_to_fc_flattener.sv
// Collects C pooled single-channel maps and serially packs the valid HxW region
// of each, channel-major, into one dense fully-connected input vector.
module pool_to_fc_flattener #(
    parameter int ELEM_WIDTH     = 8,
    parameter int MAX_IMG_HEIGHT = 32,
    parameter int MAX_IMG_WIDTH  = 32,
    parameter int INPUT_SIZE     = 128
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic [7:0]                                       cfg_height,
    input  logic [7:0]                                       cfg_width,
    input  logic [7:0]                                       cfg_channels,
    input  logic                                             map_valid,
    input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] map_data,
    output logic                                             map_ready,
    output logic                                             busy,
    output logic                                             cfg_err,
    output logic                                             map_dropped,
    output logic                                             fc_en,
    output logic [31:0]                                      fc_actual_input_size,
    output logic [INPUT_SIZE*ELEM_WIDTH-1:0]                 fc_in_vec
);

    localparam int MAP_ELEMS = MAX_IMG_HEIGHT * MAX_IMG_WIDTH;
    localparam int MAP_IDX_W = $clog2(MAP_ELEMS);
    localparam int VEC_IDX_W = $clog2(INPUT_SIZE);
    localparam int PTR_W     = VEC_IDX_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_MAP, COPY, DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ELEM_WIDTH-1:0] r_map [MAP_ELEMS];
    logic [ELEM_WIDTH-1:0] r_vec [INPUT_SIZE];
    logic [7:0]            r_h, r_w, r_c;
    logic [7:0]            r_row, r_col, r_ch;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [31:0]           r_size;
    logic                  r_cfg_err;
    logic                  r_dropped;

    logic [31:0]           w_total;
    logic                  w_cfg_ok;
    logic                  w_last_elem;
    logic [MAP_IDX_W-1:0]  w_rd_idx;

    assign w_total  = {24'd0, cfg_height} * {24'd0, cfg_width} * {24'd0, cfg_channels};
    assign w_cfg_ok = (cfg_height != 8'd0) && (cfg_width != 8'd0) && (cfg_channels != 8'd0)
                   && ({24'd0, cfg_height} <= 32'(MAX_IMG_HEIGHT))
                   && ({24'd0, cfg_width}  <= 32'(MAX_IMG_WIDTH))
                   && (w_total <= 32'(INPUT_SIZE));

    assign w_last_elem = (r_row == r_h - 8'd1) && (r_col == r_w - 8'd1);
    assign w_rd_idx    = MAP_IDX_W'(r_row) * MAP_IDX_W'(MAX_IMG_WIDTH) + MAP_IDX_W'(r_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (start && w_cfg_ok) w_state_next = WAIT_MAP;
            WAIT_MAP: if (map_valid) w_state_next = COPY;
            COPY:     if (w_last_elem) w_state_next = (r_ch + 8'd1 == r_c) ? DONE : WAIT_MAP;
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAP_ELEMS; i++) r_map[i] <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) r_vec[i] <= '0;
            r_h       <= '0;
            r_w       <= '0;
            r_c       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_wr_ptr  <= '0;
            r_size    <= '0;
            r_cfg_err <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            if (map_valid && (r_state != WAIT_MAP)) r_dropped <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_h <= cfg_height;
                        r_w <= cfg_width;
                        r_c <= cfg_channels;
                        if (!w_cfg_ok) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            for (int i = 0; i < INPUT_SIZE; i++) r_vec[i] <= '0;
                            r_size   <= w_total;
                            r_ch     <= '0;
                            r_wr_ptr <= '0;
                        end
                    end
                end
                WAIT_MAP: begin
                    if (map_valid) begin
                        for (int i = 0; i < MAP_ELEMS; i++)
                            r_map[i] <= map_data[i*ELEM_WIDTH +: ELEM_WIDTH];
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                COPY: begin
                    // Write is guarded even though a legal job never overruns the vector.
                    if (r_wr_ptr < PTR_W'(INPUT_SIZE))
                        r_vec[r_wr_ptr[VEC_IDX_W-1:0]] <= r_map[w_rd_idx];
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (r_col == r_w - 8'd1) begin
                        r_col <= '0;
                        if (r_row == r_h - 8'd1) begin
                            r_row <= '0;
                            r_ch  <= r_ch + 8'd1;
                        end else begin
                            r_row <= r_row + 8'd1;
                        end
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_vec
            assign fc_in_vec[gi*ELEM_WIDTH +: ELEM_WIDTH] = r_vec[gi];
        end
    endgenerate

    assign map_ready            = (r_state == WAIT_MAP);
    assign busy                 = (r_state != IDLE);
    assign fc_en                = (r_state == DONE);
    assign cfg_err              = r_cfg_err;
    assign map_dropped          = r_dropped;
    assign fc_actual_input_size = r_size;

endmodule
